// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one combinational 16-bit logic/compare unit between two requesters.
// Round-robin grant in IDLE, one operation in flight (IDLE -> EXEC -> RESP),
// and the result is held in registers until the consumer takes it.
module logic_unit_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_op1,
   input  logic [WIDTH-1:0] r0_op2,
   input  logic [OPW-1:0]   r0_opcode,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_op1,
   input  logic [WIDTH-1:0] r1_op2,
   input  logic [OPW-1:0]   r1_opcode,
   output logic [WIDTH-1:0] lu_op1,
   output logic [WIDTH-1:0] lu_op2,
   output logic [OPW-1:0]   lu_opcode,
   input  logic [WIDTH-1:0] lu_out,
   input  logic [4:0]       lu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic [4:0]       rsp_flags,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // The unit only defines opcodes 0100..1010; anything else is flagged.
   function automatic logic opcode_err(input logic [OPW-1:0] opc);
      return (opc < OPW'(4'b0100)) || (opc > OPW'(4'b1010));
   endfunction

   logic [1:0]       state_r;
   logic             last_grant_r;
   logic             req_id_r;
   logic [WIDTH-1:0] lu_op1_r;
   logic [WIDTH-1:0] lu_op2_r;
   logic [OPW-1:0]   lu_opcode_r;
   logic             rsp_id_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic [4:0]       rsp_flags_r;
   logic             rsp_err_r;
   logic [15:0]      op_count_r;
   logic             grant_s;
   logic             grant_id_s;

   // Round-robin pick: a lone requester wins, on contention the one not served last wins.
   always_comb begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (r0_valid && r1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = ~last_grant_r;
         end else if (r0_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b0;
         end else if (r1_valid) begin
            grant_s    = 1'b1;
            grant_id_s = 1'b1;
         end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
         end
      end else begin
         grant_s    = 1'b0;
         grant_id_s = 1'b0;
      end
   end

   assign r0_ready  = grant_s & ~grant_id_s;
   assign r1_ready  = grant_s & grant_id_s;
   assign lu_op1    = lu_op1_r;
   assign lu_op2    = lu_op2_r;
   assign lu_opcode = lu_opcode_r;
   assign rsp_valid = (state_r == ST_RESP);
   assign rsp_id    = rsp_id_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_flags = rsp_flags_r;
   assign rsp_err   = rsp_err_r;
   assign busy      = (state_r != ST_IDLE);
   assign op_count  = op_count_r;

   // Operation sequencer: capture on accept, latch the unit result, hold until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         req_id_r     <= 1'b0;
         lu_op1_r     <= '0;
         lu_op2_r     <= '0;
         lu_opcode_r  <= '0;
         rsp_id_r     <= 1'b0;
         rsp_data_r   <= '0;
         rsp_flags_r  <= 5'b00000;
         rsp_err_r    <= 1'b0;
         op_count_r   <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  lu_op1_r     <= grant_id_s ? r1_op1    : r0_op1;
                  lu_op2_r     <= grant_id_s ? r1_op2    : r0_op2;
                  lu_opcode_r  <= grant_id_s ? r1_opcode : r0_opcode;
                  req_id_r     <= grant_id_s;
                  last_grant_r <= grant_id_s;
                  state_r      <= ST_EXEC;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rsp_data_r  <= lu_out;
               rsp_flags_r <= lu_flags;
               rsp_id_r    <= req_id_r;
               rsp_err_r   <= opcode_err(lu_opcode_r);
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  op_count_r <= op_count_r + 16'd1;
                  state_r    <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: a behavioural logic unit drives lu_out/lu_flags,
// a monitor records every consumed response, and each scenario task compares
// against expectations derived from the arbitration and opcode rules.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [15:0] r0_op1, r0_op2, r1_op1, r1_op2;
   logic [3:0]  r0_opcode, r1_opcode;
   logic [15:0] lu_op1, lu_op2, lu_out;
   logic [3:0]  lu_opcode;
   logic [4:0]  lu_flags;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [15:0] rsp_data, op_count;
   logic [4:0]  rsp_flags;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rr_last;
   logic [15:0] model_cnt;

   typedef struct packed {
      logic        id;
      logic [15:0] data;
      logic [4:0]  flags;
      logic        err;
      logic [15:0] cnt;
      logic [31:0] cyc;
   } rsp_t;

   rsp_t obs_q[$];
   rsp_t exp_q[$];

   logic_unit_arbiter #(.WIDTH(16), .OPW(4)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_opcode(r0_opcode),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_opcode(r1_opcode),
      .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_opcode(lu_opcode), .lu_out(lu_out), .lu_flags(lu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural logic unit: {result, lt, gt, eq, zb, za}
   function automatic logic [20:0] unit_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] opc);
      logic [15:0] r;
      case (opc)
         4'd4:    r = a & b;
         4'd5:    r = a | b;
         4'd6:    r = a ^ b;
         4'd7:    r = ~(a & b);
         4'd8:    r = ~(a | b);
         4'd9:    r = ~(a ^ b);
         4'd10:   r = ~a;
         default: r = 16'h0000;
      endcase
      return {r, a < b, a > b, a == b, b == 16'h0000, a == 16'h0000};
   endfunction

   assign {lu_out, lu_flags} = unit_model(lu_op1, lu_op2, lu_opcode);

   function automatic rsp_t expect_rsp(input logic id, input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] opc, input logic [15:0] cnt);
      rsp_t e;
      logic [20:0] u;
      u       = unit_model(a, b, opc);
      e.id    = id;
      e.data  = u[20:5];
      e.flags = u[4:0];
      e.err   = (opc < 4'd4) || (opc > 4'd10);
      e.cnt   = cnt;
      e.cyc   = 32'd0;
      return e;
   endfunction

   // Response monitor: records each consumed response with the count before it
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready)
         obs_q.push_back({rsp_id, rsp_data, rsp_flags, rsp_err, op_count, 32'(cyc)});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and hold it until accepted (bounded); returns winner and accept cycle
   task automatic issue(input logic v0, input logic v1,
                        input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] o0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] o1,
                        output int acc_id, output int acc_cyc);
      r0_valid = v0; r0_op1 = a0; r0_op2 = b0; r0_opcode = o0;
      r1_valid = v1; r1_op1 = a1; r1_op2 = b1; r1_opcode = o1;
      acc_id  = -1;
      acc_cyc = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (r0_ready || r1_ready) begin
            acc_id  = r1_ready ? 1 : 0;
            acc_cyc = cyc;
            tick();
            break;
         end
         tick();
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
   endtask

   task automatic test_reset();
      int id, ac;
      n_checks++;
      if ({rsp_valid, busy, op_count, lu_op1, lu_op2, lu_opcode, r0_ready, r1_ready} !== 56'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b busy=%b cnt=%h lu=%h/%h/%h, want all zero",
                  rsp_valid, busy, op_count, lu_op1, lu_op2, lu_opcode);
      end
      rst = 1'b0;
      tick();
      issue(1'b1, 1'b0, 16'h1234, 16'h00FF, 4'd6, 16'h0, 16'h0, 4'd0, id, ac);
      n_checks++;
      if ({busy, rsp_valid, lu_op1} !== {1'b1, 1'b0, 16'h1234}) begin
         n_fail++;
         $display("FAIL reset_exec_entry: got busy=%b v=%b op1=%h, want 1 0 1234", busy, rsp_valid, lu_op1);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, busy, op_count, lu_op1, lu_op2, lu_opcode} !== 54'd0) begin
         n_fail++;
         $display("FAIL reset_mid_exec: got v=%b busy=%b cnt=%h lu=%h/%h/%h, want all zero",
                  rsp_valid, busy, op_count, lu_op1, lu_op2, lu_opcode);
      end
      tick();
      rst = 1'b0;
      rr_last = 1;
      model_cnt = 16'h0000;
      rsp_ready = 1'b1;
      repeat (4) tick();
      rsp_ready = 1'b0;
      n_checks++;
      if ({obs_q.size() == 0, rsp_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_discard: got responses=%0d v=%b busy=%b, want 0 0 0",
                  obs_q.size(), rsp_valid, busy);
      end
   endtask

   task automatic test_r0_alone();
      int id, ac;
      rsp_t e;
      rsp_ready = 1'b0;
      obs_q.delete();
      issue(1'b1, 1'b0, 16'h00F0, 16'h0F0F, 4'b0101, 16'h0, 16'h0, 4'd0, id, ac);
      n_checks++;
      if (id !== 0) begin
         n_fail++;
         $display("FAIL r0_grant: got id %0d, want 0", id);
      end
      rr_last = 0;
      n_checks++;
      if ({rsp_valid, busy, lu_op1, lu_op2, lu_opcode} !== {1'b0, 1'b1, 16'h00F0, 16'h0F0F, 4'b0101}) begin
         n_fail++;
         $display("FAIL r0_exec: got v=%b busy=%b lu=%h/%h/%h, want 0 1 00f0/0f0f/5",
                  rsp_valid, busy, lu_op1, lu_op2, lu_opcode);
      end
      tick();
      e = expect_rsp(1'b0, 16'h00F0, 16'h0F0F, 4'b0101, model_cnt);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err} !== {1'b1, 1'b0, 16'h0FFF, e.flags, 1'b0}
          || (cyc - ac) != 2) begin
         n_fail++;
         $display("FAIL r0_response: got v=%b id=%b data=%h flags=%b err=%b lat=%0d, want 1 0 0fff %b 0 lat=2",
                  rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, cyc - ac, e.flags);
      end
      rsp_ready = 1'b1;
      tick();
      model_cnt++;
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, model_cnt}) begin
         n_fail++;
         $display("FAIL r0_complete: got v=%b busy=%b cnt=%h, want 0 0 %h", rsp_valid, busy, op_count, model_cnt);
      end
   endtask

   task automatic test_round_robin();
      int id, ac, prev_ac, eid;
      logic [15:0] a0, b0, a1, b1;
      logic [3:0]  o0, o1;
      rsp_t o, e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rr_last = 1;
      model_cnt = 16'h0000;
      obs_q.delete();
      exp_q.delete();
      rsp_ready = 1'b1;
      prev_ac = 0;
      for (int k = 0; k < 4; k++) begin
         a0 = 16'($urandom); b0 = 16'($urandom); o0 = 4'($urandom_range(4, 10));
         a1 = 16'($urandom); b1 = 16'($urandom); o1 = 4'($urandom_range(4, 10));
         eid = (rr_last == 1) ? 0 : 1;
         issue(1'b1, 1'b1, a0, b0, o0, a1, b1, o1, id, ac);
         n_checks++;
         if (id !== eid || (k > 0 && (ac - prev_ac) != 3)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got id %0d spacing %0d, want id %0d spacing 3", k, id, ac - prev_ac, eid);
         end
         prev_ac = ac;
         rr_last = eid;
         exp_q.push_back(expect_rsp(eid[0], eid ? a1 : a0, eid ? b1 : b0, eid ? o1 : o0, model_cnt));
         model_cnt++;
      end
      for (int i = 0; i < 10 && obs_q.size() < 4; i++) tick();
      n_checks++;
      if (obs_q.size() != 4) begin
         n_fail++;
         $display("FAIL rr_count: got %0d responses, want 4", obs_q.size());
      end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         o = obs_q[i];
         e = exp_q[i];
         n_checks++;
         if ({o.id, o.data, o.flags, o.err, o.cnt} !== {e.id, e.data, e.flags, e.err, e.cnt}
             || (i > 0 && (o.cyc - obs_q[i-1].cyc) != 3)) begin
            n_fail++;
            $display("FAIL rr_rsp%0d: got id=%b data=%h flags=%b err=%b cnt=%h, want %b %h %b %b %h (3-cycle spacing)",
                     i, o.id, o.data, o.flags, o.err, o.cnt, e.id, e.data, e.flags, e.err, e.cnt);
         end
      end
      tick();
      rsp_ready = 1'b0;
      n_checks++;
      if (op_count !== 16'd4) begin
         n_fail++;
         $display("FAIL rr_op_count: got %h, want 0004", op_count);
      end
   endtask

   task automatic test_backpressure();
      int id, ac;
      logic [15:0] a, b;
      logic [3:0]  opc;
      rsp_t e;
      rsp_ready = 1'b0;
      a = 16'($urandom); b = 16'($urandom); opc = 4'($urandom_range(4, 10));
      issue(1'b0, 1'b1, 16'hAAAA, 16'h5555, 4'd4, a, b, opc, id, ac);
      n_checks++;
      if (id !== 1) begin
         n_fail++;
         $display("FAIL bp_grant: got id %0d, want 1", id);
      end
      rr_last = 1;
      e = expect_rsp(1'b1, a, b, opc, model_cnt);
      r0_valid = 1'b1; r1_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         r0_op1 = 16'($urandom); r1_op2 = 16'($urandom); r0_opcode = 4'($urandom);
         #1;
         n_checks++;
         if ({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err}
             !== {1'b0, 1'b0, 1'b1, e.id, e.data, e.flags, e.err}) begin
            n_fail++;
            $display("FAIL bp_stall%0d: got rdy=%b%b v=%b id=%b data=%h flags=%b err=%b, want 00 1 %b %h %b %b",
                     i, r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err,
                     e.id, e.data, e.flags, e.err);
         end
         tick();
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      model_cnt++;
      n_checks++;
      if ({busy, rsp_valid, op_count} !== {1'b0, 1'b0, model_cnt}) begin
         n_fail++;
         $display("FAIL bp_release: got busy=%b v=%b cnt=%h, want 0 0 %h", busy, rsp_valid, op_count, model_cnt);
      end
   endtask

   task automatic test_err_opcode();
      int id, ac;
      rsp_ready = 1'b0;
      issue(1'b1, 1'b0, 16'h0000, 16'h0000, 4'b1111, 16'h0, 16'h0, 4'd0, id, ac);
      rr_last = 0;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_data, rsp_flags} !== {1'b1, 1'b1, 16'h0000, 5'b00111}) begin
         n_fail++;
         $display("FAIL err_opcode: got v=%b err=%b data=%h flags=%b, want 1 1 0000 00111",
                  rsp_valid, rsp_err, rsp_data, rsp_flags);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      model_cnt++;
   endtask

   task automatic test_random();
      int id, ac, eid, v, stall;
      logic [15:0] a0, b0, a1, b1;
      logic [3:0]  o0, o1;
      rsp_t o, e;
      obs_q.delete();
      exp_q.delete();
      rsp_ready = 1'b0;
      for (int k = 0; k < 24; k++) begin
         v = $urandom_range(1, 3);
         a0 = 16'($urandom); b0 = ($urandom_range(0, 3) == 0) ? a0 : 16'($urandom); o0 = 4'($urandom);
         a1 = 16'($urandom); b1 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom); o1 = 4'($urandom);
         if (v == 3) eid = (rr_last == 1) ? 0 : 1;
         else        eid = (v == 2) ? 1 : 0;
         issue(v[0], v[1], a0, b0, o0, a1, b1, o1, id, ac);
         n_checks++;
         if (id !== eid) begin
            n_fail++;
            $display("FAIL rand_grant%0d: got id %0d, want %0d (valids %0d)", k, id, eid, v);
         end
         rr_last = eid;
         exp_q.push_back(expect_rsp(eid[0], eid ? a1 : a0, eid ? b1 : b0, eid ? o1 : o0, model_cnt));
         model_cnt++;
         stall = $urandom_range(0, 3);
         repeat (stall + 1) tick();
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         o = obs_q[i];
         e = exp_q[i];
         n_checks++;
         if ({o.id, o.data, o.flags, o.err, o.cnt} !== {e.id, e.data, e.flags, e.err, e.cnt}) begin
            n_fail++;
            $display("FAIL rand_rsp%0d: got id=%b data=%h flags=%b err=%b cnt=%h, want %b %h %b %b %h",
                     i, o.id, o.data, o.flags, o.err, o.cnt, e.id, e.data, e.flags, e.err, e.cnt);
         end
      end
   endtask

   task automatic test_wrap();
      int id, ac;
      force dut.op_count_r = 16'hFFFE;
      #1;
      release dut.op_count_r;
      model_cnt = 16'hFFFE;
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         issue(1'b1, 1'b0, 16'($urandom), 16'($urandom), 4'd5, 16'h0, 16'h0, 4'd0, id, ac);
         tick();
         tick();
         model_cnt++;
         n_checks++;
         if (op_count !== model_cnt) begin
            n_fail++;
            $display("FAIL wrap%0d: got op_count %h, want %h", k, op_count, model_cnt);
         end
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      r0_valid = 1'b0; r0_op1 = 16'h0; r0_op2 = 16'h0; r0_opcode = 4'd0;
      r1_valid = 1'b0; r1_op1 = 16'h0; r1_op2 = 16'h0; r1_opcode = 4'd0;
      rsp_ready = 1'b0;
      rr_last = 1;
      model_cnt = 16'h0000;
      repeat (2) tick();
      test_reset();
      test_r0_alone();
      test_round_robin();
      test_backpressure();
      test_err_opcode();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
